// File: rtl/user_move_entry.sv
// user_move_entry: turns an ASCII byte stream into a validated square number
// for an N x N board. Only legal moves reach the engine (o_move plus a
// one-cycle strobe). Malformed, out-of-range, occupied or stale entries are
// reported through an error strobe and code instead.
module user_move_entry #(
  parameter  int BOARD_N        = 3,
  parameter  int TIMEOUT_CYCLES = 100_000_000,
  localparam int SQ             = BOARD_N * BOARD_N,
  localparam int MW             = $clog2(SQ + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [2*SQ-1:0]   i_board,
  input  logic              i_needinput,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_stb,
  output logic [MW-1:0]     o_move,
  output logic              o_validmove_stb,
  output logic              o_error_stb,
  output logic [1:0]        o_error_code,
  output logic              o_busy
);

  // SQ tops out at 81, so an entry never needs more than two digits
  localparam int MAXD = (SQ >= 10) ? 2 : 1;
  // accumulator holds any MAXD-digit number, so it can never wrap
  localparam int AW   = $clog2(10 ** MAXD);
  localparam int CW   = $clog2(MAXD + 1);
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] E_BADCHAR  = 2'd0;
  localparam logic [1:0] E_RANGE    = 2'd1;
  localparam logic [1:0] E_OCCUPIED = 2'd2;
  localparam logic [1:0] E_TIMEOUT  = 2'd3;

  typedef struct packed {
    logic          ovf;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
  } entry_t;

  logic [1:0]    state;
  logic          armed;
  entry_t        ent;
  logic [TW-1:0] tcnt;

  logic is_dig, is_clr, is_spc, is_eol;
  logic [SQ:0] sq_occ;
  logic        occ;
  logic        range_bad;
  logic        to_hit;

  assign is_dig = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
  assign is_clr = (i_rx_data == 8'h08) || (i_rx_data == 8'h7F);
  assign is_spc = (i_rx_data == 8'h20);
  assign is_eol = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);

  // per-square occupancy; square 1 sits in the top two bits of i_board
  assign sq_occ[0] = 1'b0;
  for (genvar k = 1; k <= SQ; k++) begin : g_sq
    assign sq_occ[k] = |i_board[2*(SQ-k) +: 2];
  end

  // occupancy of the square named by the accumulator (0 when out of range)
  always_comb begin
    occ = 1'b0;
    for (int k = 1; k <= SQ; k++)
      if (ent.acc == AW'(k)) occ = sq_occ[k];
  end

  assign range_bad = ent.ovf || (ent.acc == '0) || (ent.acc > AW'(SQ));
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign o_busy    = (state == S_COLLECT) && (ent.cnt != '0);

  // entry FSM: collect digits, validate against range and board, commit once
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= S_IDLE;
      armed           <= 1'b1;
      ent             <= '0;
      tcnt            <= '0;
      o_move          <= '0;
      o_validmove_stb <= 1'b0;
      o_error_stb     <= 1'b0;
      o_error_code    <= E_BADCHAR;
    end else begin
      o_validmove_stb <= 1'b0;
      o_error_stb     <= 1'b0;
      // re-arm only after the engine has stopped asking for a cycle
      if (!i_needinput) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          ent  <= '0;
          tcnt <= '0;
          if (i_needinput && armed) state <= S_COLLECT;
        end

        S_COLLECT: begin
          if (!i_needinput) begin
            // engine withdrew the request: abandon silently
            state <= S_IDLE;
            ent   <= '0;
            tcnt  <= '0;
          end else if (i_rx_stb) begin
            tcnt <= '0;
            if (is_dig) begin
              if (ent.cnt == CW'(MAXD)) begin
                ent.ovf <= 1'b1;
              end else begin
                ent.acc <= AW'(32'(ent.acc) * 32'd10 + 32'(i_rx_data[3:0]));
                ent.cnt <= ent.cnt + 1'b1;
              end
            end else if (is_clr) begin
              ent <= '0;
            end else if (is_spc) begin
              ent <= ent;
            end else if (is_eol) begin
              // blank lines and the LF of CRLF fall through harmlessly
              if (ent.cnt != '0) state <= S_CHECK;
            end else begin
              ent          <= '0;
              o_error_stb  <= 1'b1;
              o_error_code <= E_BADCHAR;
            end
          end else if (to_hit) begin
            ent          <= '0;
            tcnt         <= '0;
            o_error_stb  <= 1'b1;
            o_error_code <= E_TIMEOUT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_CHECK: begin
          tcnt <= '0;
          if (range_bad) begin
            ent          <= '0;
            state        <= S_COLLECT;
            o_error_stb  <= 1'b1;
            o_error_code <= E_RANGE;
          end else if (occ) begin
            ent          <= '0;
            state        <= S_COLLECT;
            o_error_stb  <= 1'b1;
            o_error_code <= E_OCCUPIED;
          end else begin
            o_move          <= ent.acc[MW-1:0];
            o_validmove_stb <= 1'b1;
            state           <= S_DONE;
            if (i_needinput) armed <= 1'b0;
          end
        end

        default: begin  // S_DONE
          ent   <= '0;
          tcnt  <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_move_entry.sv
// Bench for user_move_entry: three instances (N=3, N=4, N=3 with a short
// timeout). A text-level model tracks the digits typed so far as a list and
// decides each byte's outcome from the entry rules; strobe timing, codes,
// o_move and o_busy are compared after every byte.
module tb_user_move_entry;

  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A, BS = 8'h08, DEL = 8'h7F, SP = 8'h20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       ni  [3];
  logic       rxs [3];
  logic [7:0] rxd;
  logic [17:0] brd0, brd2;
  logic [31:0] brd1;

  logic [3:0] mv0, mv2;
  logic [4:0] mv1;
  logic       vs [3];
  logic       es [3];
  logic       busy [3];
  logic [1:0] ec [3];

  user_move_entry #(.BOARD_N(3)) dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_board(brd0), .i_needinput(ni[0]),
    .i_rx_data(rxd), .i_rx_stb(rxs[0]), .o_move(mv0), .o_validmove_stb(vs[0]),
    .o_error_stb(es[0]), .o_error_code(ec[0]), .o_busy(busy[0]));

  user_move_entry #(.BOARD_N(4)) dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_board(brd1), .i_needinput(ni[1]),
    .i_rx_data(rxd), .i_rx_stb(rxs[1]), .o_move(mv1), .o_validmove_stb(vs[1]),
    .o_error_stb(es[1]), .o_error_code(ec[1]), .o_busy(busy[1]));

  user_move_entry #(.BOARD_N(3), .TIMEOUT_CYCLES(20)) dut2 (
    .i_clk(clk), .i_reset(rst[2]), .i_board(brd2), .i_needinput(ni[2]),
    .i_rx_data(rxd), .i_rx_stb(rxs[2]), .o_move(mv2), .o_validmove_stb(vs[2]),
    .o_error_stb(es[2]), .o_error_code(ec[2]), .o_busy(busy[2]));

  int nchk = 0;
  int nerr = 0;

  // reference model state, one slot per instance
  int         mdig [3][$];
  bit         mcol [3];
  bit         marm [3];
  int         mmove [3];
  int         mcode [3];
  logic [1:0] mcell [3][1:16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sqn(input int sel);
    return (sel == 1) ? 16 : 9;
  endfunction

  function automatic int maxd(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mvf(input int sel);
    case (sel)
      0:       return 32'(mv0);
      1:       return 32'(mv1);
      default: return 32'(mv2);
    endcase
  endfunction

  task automatic apply_board(input int sel);
    logic [31:0] v;
    int sq;
    v  = '0;
    sq = sqn(sel);
    for (int k = 1; k <= sq; k++) v[2*(sq-k) +: 2] = mcell[sel][k];
    case (sel)
      0:       brd0 = v[17:0];
      1:       brd1 = v;
      default: brd2 = v[17:0];
    endcase
  endtask

  task automatic rand_board(input int sel);
    for (int k = 1; k <= sqn(sel); k++)
      mcell[sel][k] = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
    apply_board(sel);
  endtask

  task automatic check_state(input int sel, input string tag);
    chk($sformatf("%s_move%0d", tag, sel), mvf(sel), 32'(mmove[sel]));
    chk($sformatf("%s_code%0d", tag, sel), 32'(ec[sel]), 32'(mcode[sel]));
    chk($sformatf("%s_busy%0d", tag, sel), 32'(busy[sel]),
        32'(mcol[sel] && (mdig[sel].size() > 0)));
  endtask

  // send one byte and watch the three cycles after it for strobes
  task automatic send_byte(input int sel, input logic [7:0] b);
    logic [2:0] evs, ees, gvs, ges;
    int v;
    evs = '0;
    ees = '0;
    if (mcol[sel]) begin
      if (b >= 8'h30 && b <= 8'h39) begin
        mdig[sel].push_back(int'(b) - 48);
      end else if (b == BS || b == DEL) begin
        mdig[sel].delete();
      end else if (b == SP) begin
        v = 0;
      end else if (b == CR || b == LF) begin
        if (mdig[sel].size() > 0) begin
          v = 0;
          for (int i = 0; i < mdig[sel].size(); i++) v = v * 10 + mdig[sel][i];
          if (mdig[sel].size() > maxd(sel) || v == 0 || v > sqn(sel)) begin
            ees = 3'b010; mcode[sel] = 1;
          end else if (mcell[sel][v] != 2'd0) begin
            ees = 3'b010; mcode[sel] = 2;
          end else begin
            evs = 3'b010; mmove[sel] = v; mcol[sel] = 0; marm[sel] = 0;
          end
          mdig[sel].delete();
        end
      end else begin
        ees = 3'b001; mcode[sel] = 0;
        mdig[sel].delete();
      end
    end
    rxd      = b;
    rxs[sel] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) rxs[sel] = 1'b0;
      gvs[i] = vs[sel];
      ges[i] = es[sel];
    end
    chk($sformatf("vstb%0d_b%02h", sel, b), 32'(gvs), 32'(evs));
    chk($sformatf("estb%0d_b%02h", sel, b), 32'(ges), 32'(ees));
    check_state(sel, "byte");
  endtask

  task automatic send_str(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
  endtask

  task automatic set_ni(input int sel, input logic v);
    logic [3:0] st;
    ni[sel] = v;
    @(negedge clk); st[0] = vs[sel]; st[1] = es[sel];
    @(negedge clk); st[2] = vs[sel]; st[3] = es[sel];
    if (!v) begin
      mcol[sel] = 0; marm[sel] = 1; mdig[sel].delete();
    end else if (marm[sel]) begin
      mcol[sel] = 1;
    end
    chk($sformatf("ni_quiet%0d", sel), 32'(st), 32'd0);
  endtask

  task automatic do_reset(input int sel);
    rst[sel] = 1'b1;
    @(negedge clk);
    rst[sel]   = 1'b0;
    mcol[sel]  = 0; marm[sel] = 1; mmove[sel] = 0; mcode[sel] = 0;
    mdig[sel].delete();
    chk($sformatf("rst_vstb%0d", sel), 32'(vs[sel]), 32'd0);
    chk($sformatf("rst_estb%0d", sel), 32'(es[sel]), 32'd0);
    check_state(sel, "rst");
    @(negedge clk);
    chk($sformatf("rst_quiet%0d", sel), 32'({vs[sel], es[sel]}), 32'd0);
    if (ni[sel]) mcol[sel] = 1;
  endtask

  task automatic rand_run(input int sel, input int n);
    int r;
    logic [7:0] b;
    set_ni(sel, 1'b1);
    repeat (n) begin
      r = $urandom_range(0, 99);
      if (r < 4)       set_ni(sel, 1'b0);
      else if (r < 10) set_ni(sel, 1'b1);
      else if (r < 13) rand_board(sel);
      else begin
        r = $urandom_range(0, 99);
        if (r < 50)      b = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 68) b = CR;
        else if (r < 73) b = LF;
        else if (r < 77) b = BS;
        else if (r < 79) b = DEL;
        else if (r < 83) b = SP;
        else             b = 8'($urandom_range(0, 255));
        send_byte(sel, b);
      end
    end
    set_ni(sel, 1'b0);
  endtask

  initial begin
    int t1, t2, nes;
    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1; ni[s] = 1'b0; rxs[s] = 1'b0;
      mcol[s] = 0; marm[s] = 1; mmove[s] = 0; mcode[s] = 0;
      for (int k = 1; k <= 16; k++) mcell[s][k] = 2'd0;
    end
    rxd = 8'h00;
    brd0 = '0; brd1 = '0; brd2 = '0;
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 3; s++) rst[s] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("init_vstb%0d", s), 32'(vs[s]), 32'd0);
      chk($sformatf("init_estb%0d", s), 32'(es[s]), 32'd0);
      check_state(s, "init");
    end

    // N=3 directed scenarios
    set_ni(0, 1'b1);
    send_str(0, "5"); send_byte(0, CR);
    chk("first_move", mvf(0), 32'd5);
    set_ni(0, 1'b0); set_ni(0, 1'b1);
    send_str(0, "10"); send_byte(0, CR);
    chk("range_code", 32'(ec[0]), 32'd1);
    send_str(0, "0"); send_byte(0, CR);
    send_str(0, "4x");
    chk("badchar_code", 32'(ec[0]), 32'd0);
    mcell[0][5] = 2'b01; apply_board(0);
    send_str(0, "5"); send_byte(0, CR);
    chk("occ_code", 32'(ec[0]), 32'd2);
    send_str(0, "7"); send_byte(0, CR); send_byte(0, LF);
    chk("move7", mvf(0), 32'd7);
    send_str(0, "2"); send_byte(0, CR);   // still held high: must be dropped
    chk("no_recommit", mvf(0), 32'd7);
    set_ni(0, 1'b0); set_ni(0, 1'b1);
    send_str(0, " 2"); send_byte(0, CR);
    chk("move2", mvf(0), 32'd2);
    // reset in the middle of an entry
    set_ni(0, 1'b0); set_ni(0, 1'b1);
    send_str(0, "4");
    do_reset(0);
    send_byte(0, CR);
    set_ni(0, 1'b0);

    // N=4 directed scenarios
    set_ni(1, 1'b1);
    send_str(1, "16"); send_byte(1, CR);
    chk("move16", mvf(1), 32'd16);
    set_ni(1, 1'b0); set_ni(1, 1'b1);
    send_str(1, "17"); send_byte(1, CR);
    send_str(1, "123"); send_byte(1, CR);
    send_str(1, "09"); send_byte(1, BS); send_str(1, "3"); send_byte(1, CR);
    chk("move3", mvf(1), 32'd3);
    set_ni(1, 1'b0);

    // timeout: '3' then silence; a byte landing on the expiry cycle wins
    ni[2] = 1'b1;
    @(negedge clk); @(negedge clk);
    rxd = "3"; rxs[2] = 1'b1;
    t1 = -1; t2 = -1; nes = 0;
    for (int j = 0; j <= 70; j++) begin
      @(negedge clk);
      if (es[2]) begin
        nes++;
        if (t1 < 0) t1 = j; else if (t2 < 0) t2 = j;
        chk("to_code", 32'(ec[2]), 32'd3);
      end
      if (j == 0) begin rxs[2] = 1'b0; chk("to_busy_pre", 32'(busy[2]), 32'd1); end
      if (j == 20) chk("to_busy_post", 32'(busy[2]), 32'd0);
      if (j == 39) begin rxd = "1"; rxs[2] = 1'b1; end
      if (j == 40) rxs[2] = 1'b0;
      if (j == 41) chk("to_busy_new", 32'(busy[2]), 32'd1);
    end
    chk("to_first", 32'(t1), 32'd20);
    chk("to_second", 32'(t2), 32'd60);
    chk("to_count", 32'(nes), 32'd2);
    ni[2] = 1'b0;
    @(negedge clk);

    // randomized traffic on both board sizes
    rand_run(0, 250);
    rand_run(1, 250);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
